// File: rtl/rtc_seg_scan.sv
// rtc_seg_scan: scans a BCD HH.MM.SS time onto a 6-digit multiplexed 7-segment display.
// The time is latched once per frame; every digit switch is followed by a blanking gap.
module rtc_seg_scan #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1_000,
    parameter int BLANK_CYC  = 16,
    parameter bit SEG_ACT_LO = 1'b1,
    parameter bit DIG_ACT_LO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] second,
    input  logic [7:0] minute,
    input  logic [7:0] hour,
    output logic [7:0] seg,
    output logic [5:0] dig
);
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(BLANK_CYC + 2);
    localparam logic [7:0] SEG_OFF = {8{SEG_ACT_LO}};
    localparam logic [5:0] DIG_OFF = {6{DIG_ACT_LO}};
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   snap_q, snap_d;
    logic [BW-1:0] blank_q, blank_d;
    logic          run_q, run_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    dig_q, dig_d;
    logic          tick, lead_blank, dp;
    logic [3:0]    nib;

    // Decode works on the next digit and next snapshot so segments settle during the blank gap.
    always_comb begin
        tick       = cnt_q == CW'(SCAN_DIV - 1);
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = tick ? (idx_q >= 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
        snap_d     = (tick && idx_q == 3'd5) ? {hour & 8'h3F, minute & 8'h7F, second & 8'h7F} : snap_q;
        nib        = 4'(snap_d >> {idx_d, 2'b00});
        lead_blank = idx_d == 3'd5 && nib == 4'd0;
        dp         = (idx_d == 3'd4 || idx_d == 3'd2) && snap_d[0];
        seg_d      = tick ? {dp, lead_blank ? 7'h00 : GLYPH[nib]} ^ SEG_OFF : seg_q;
        blank_d    = tick ? BW'(BLANK_CYC) : (blank_q != '0 ? blank_q - 1'b1 : blank_q);
        run_d      = run_q | tick;
        dig_d      = tick ? DIG_OFF : ((run_q && blank_q == '0) ? (6'b1 << idx_q) ^ DIG_OFF : dig_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            blank_q <= '0;
            run_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            blank_q <= blank_d;
            run_q   <= run_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign seg = seg_q;
    assign dig = dig_q;
endmodule

// File: tb/tb_rtc_seg_scan.sv
// tb_rtc_seg_scan: randomized and directed checks of rtc_seg_scan against a timeline model.
module tb_rtc_seg_scan;
    localparam int CLK_HZ = 1000, SCAN_HZ = 100, BLANK_CYC = 2;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] second = 8'h00, minute = 8'h00, hour = 8'h00;
    logic [7:0] seg;
    logic [5:0] dig;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    initial if (SCAN_DIV < BLANK_CYC + 2) $error("illegal config: SCAN_DIV=%0d BLANK_CYC=%0d", SCAN_DIV, BLANK_CYC);

    rtc_seg_scan #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYC(BLANK_CYC), .SEG_ACT_LO(1'b1), .DIG_ACT_LO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .second(second), .minute(minute), .hour(hour), .seg(seg), .dig(dig)
    );

    // Model: m clock edges since reset; tick t = m/SCAN_DIV shows digit t%6; every 6th tick takes a snapshot.
    int m;
    logic [23:0] msnap;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= 0;
            msnap <= '0;
        end else begin
            m <= m + 1;
            if ((m + 1) % SCAN_DIV == 0 && ((m + 1) / SCAN_DIV) % 6 == 0)
                msnap <= {hour & 8'h3F, minute & 8'h7F, second & 8'h7F};
        end
    end

    function automatic logic [7:0] exp_seg(int mm, logic [23:0] s);
        int t = mm / SCAN_DIV;
        int d = t % 6;
        logic [3:0] nib = 4'(s >> (4 * d));
        logic [7:0] a;
        if (t == 0) return 8'hFF;
        a = {1'b0, nib > 4'd9 ? 7'h40 : GLYPH[int'(nib)]};
        if (d == 5 && nib == 4'd0) a = 8'h00;
        if ((d == 4 || d == 2) && s[0]) a[7] = 1'b1;
        return ~a;
    endfunction

    function automatic logic [5:0] exp_dig(int mm);
        int t = mm / SCAN_DIV;
        if (t == 0 || mm % SCAN_DIV <= BLANK_CYC) return 6'h3F;
        return ~(6'b1 << (t % 6));
    endfunction

    always @(negedge clk) begin
        logic [7:0] es;
        logic [5:0] ed;
        es = exp_seg(m, msnap);
        ed = exp_dig(m);
        vectors++;
        if (dig !== ed || seg !== es) begin
            miscompares++;
            $display("FAIL scan m=%0d: dig=%h seg=%h, expected dig=%h seg=%h", m, dig, seg, ed, es);
        end
        vectors++;
        if ($countones(~dig) > 1) begin
            miscompares++;
            $display("FAIL onehot m=%0d: dig=%h, expected at most one active", m, dig);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_dig(input logic [5:0] v, output logic [7:0] s);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dig === v) begin
                s = seg;
                return;
            end
        end
        s = 8'hxx;
        vectors++;
        miscompares++;
        $display("FAIL timeout waiting for dig=%h", v);
    endtask

    initial begin
        logic [7:0] s;
        int n;
        repeat (3) @(negedge clk);
        check("reset_dig", 32'(dig), 32'h3F);
        check("reset_seg", 32'(seg), 32'hFF);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (dig === 6'h3F && n < 100);
        check("first_active_cycle", n, 13);
        check("first_digit", 32'(dig), 32'h3D);
        n = 0;
        while (dig === 6'h3D && n < 50) begin @(negedge clk); n++; end
        check("first_pulse_len", n, 7);

        {hour, minute, second} = {8'h23, 8'h59, 8'h41};
        wait_dig(6'h3E, s); check("dec_s1", 32'(s), 32'hF9);
        wait_dig(6'h3D, s); check("dec_s10", 32'(s), 32'h99);
        wait_dig(6'h3B, s); check("dec_m1", 32'(s), 32'h10);
        wait_dig(6'h37, s); check("dec_m10", 32'(s), 32'h92);
        wait_dig(6'h2F, s); check("dec_h1", 32'(s), 32'h30);
        wait_dig(6'h1F, s); check("dec_h10", 32'(s), 32'hA4);

        wait_dig(6'h3B, s);
        minute = 8'h00;
        wait_dig(6'h37, s); check("coh_same_frame", 32'(s), 32'h92);
        wait_dig(6'h3B, s); check("coh_next_m1", 32'(s), 32'h40);
        wait_dig(6'h37, s); check("coh_next_m10", 32'(s), 32'hC0);

        {hour, minute, second} = {8'h4A, 8'h12, 8'h80};
        wait_dig(6'h3E, s); check("mask_s1", 32'(s), 32'hC0);
        wait_dig(6'h3D, s); check("mask_s10", 32'(s), 32'hC0);
        wait_dig(6'h2F, s); check("dash_h1", 32'(s), 32'hBF);
        wait_dig(6'h1F, s); check("blank_h10", 32'(s), 32'hFF);

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0)
                {hour, minute, second} = {8'($urandom), 8'($urandom), 8'($urandom)};
            if ($urandom_range(0, 3) == 0)
                {hour, minute, second} = {2'($urandom), 2'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                                          1'($urandom), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                                          1'($urandom), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        end

        wait_dig(6'h37, s);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dig", 32'(dig), 32'h3F);
        check("async_rst_seg", 32'(seg), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
